// File: rtl/mcp23017_pkg.sv
// rtl/mcp23017_pkg.sv - shared register constants and state type for the MCP23017 sequencer
package mcp23017_pkg;

  localparam logic [7:0] IODIRA      = 8'h00;
  localparam logic [7:0] GPIOA       = 8'h12;
  localparam int         FRAME_BYTES = 4;

  typedef enum logic [2:0] {
    STARTUP,
    INIT_SEND,
    INIT_WAIT,
    IDLE,
    GPIO_SEND,
    GPIO_WAIT,
    FAULT
  } state_t;

endpackage

// File: rtl/mcp23017_sequencer.sv
// rtl/mcp23017_sequencer.sv - IODIR setup then coalesced GPIOA/GPIOB writes to an MCP23017
// Owns retries on NACK; init failure is sticky, a failed GPIO write is dropped with an err pulse.
module mcp23017_sequencer
  import mcp23017_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h20,
  parameter int unsigned STARTUP_CYCLES = 1000,
  parameter int unsigned RETRY_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        port_valid,
  input  logic [15:0] port_data,
  output logic        port_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  input  logic        tx_done,
  input  logic        tx_nack,
  output logic        init_done,
  output logic        busy,
  output logic        fault,
  output logic        err
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] retry_q, retry_d;
  logic [1:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic [15:0] snap_q, snap_d;
  logic        init_done_q, init_done_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STARTUP;
      cnt_q       <= '0;
      retry_q     <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      snap_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      snap_q      <= snap_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    snap_d      = snap_q;
    init_done_d = init_done_q;
    err_d       = 1'b0;
    accept      = port_valid && ready_q;

    case (state_q)
      STARTUP: begin
        if (cnt_q >= STARTUP_CYCLES - 1) begin
          state_d = INIT_SEND;
          idx_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      INIT_SEND, GPIO_SEND: begin
        if (tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == LAST_IDX) state_d = (state_q == INIT_SEND) ? INIT_WAIT : GPIO_WAIT;
        end
      end
      INIT_WAIT, GPIO_WAIT: begin
        if (tx_done) begin
          if (!tx_nack) begin
            if (state_q == INIT_WAIT) init_done_d = 1'b1;
            state_d = IDLE;
          end else if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 32'd1;
            idx_d   = '0;
            state_d = (state_q == INIT_WAIT) ? INIT_SEND : GPIO_SEND;
          end else if (state_q == INIT_WAIT) begin
            state_d = FAULT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        // The pending value moves to the snapshot; a same-cycle accept re-fills pending below.
        if (pend_q) begin
          snap_d  = pend_data_q;
          pend_d  = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          state_d = GPIO_SEND;
        end
      end
      FAULT:   pend_d  = 1'b0;
      default: state_d = STARTUP;
    endcase

    if (accept) begin
      pend_d      = 1'b1;
      pend_data_d = port_data;
    end
    ready_d = (state_d != FAULT);
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    if (state_q == INIT_SEND || state_q == GPIO_SEND) begin
      tx_valid = 1'b1;
      tx_last  = (idx_q == LAST_IDX);
      case ({state_q == GPIO_SEND, idx_q})
        3'b000, 3'b100: tx_data = {DEV_ADDR, 1'b0};
        3'b001:         tx_data = IODIRA;
        3'b101:         tx_data = GPIOA;
        3'b110:         tx_data = snap_q[7:0];
        3'b111:         tx_data = snap_q[15:8];
        default:        tx_data = 8'h00;
      endcase
    end
  end

  assign busy       = (state_q == INIT_SEND) || (state_q == INIT_WAIT) ||
                      (state_q == GPIO_SEND) || (state_q == GPIO_WAIT);
  assign fault      = (state_q == FAULT);
  assign init_done  = init_done_q;
  assign err        = err_q;
  assign port_ready = ready_q;

endmodule

// File: tb/tb_mcp23017_sequencer.sv
// tb/tb_mcp23017_sequencer.sv - scoreboard bench with a behavioural transmitter and frame model
module tb_mcp23017_sequencer;

  localparam int         SC   = 10;
  localparam int         RL   = 2;
  localparam logic [6:0] ADDR = 7'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        port_valid = 1'b0;
  logic [15:0] port_data = 16'h0;
  logic        port_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_ready;
  logic        tx_done;
  logic        tx_nack;
  logic        init_done;
  logic        busy;
  logic        fault;
  logic        err;

  mcp23017_sequencer #(.DEV_ADDR(ADDR), .STARTUP_CYCLES(SC), .RETRY_LIMIT(RL)) dut (
    .clk(clk), .rst(rst), .port_valid(port_valid), .port_data(port_data),
    .port_ready(port_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_nack(tx_nack), .init_done(init_done),
    .busy(busy), .fault(fault), .err(err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  int         nack_left = 0;
  int         stall_left = 0;
  int         stall_hits = 0;
  int         done_timer = 0;
  int         byte_cnt = 0;
  int         err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: address byte, register pointer, then two data bytes (IODIR frames carry zeros).
  function automatic void push_frame(input bit gpio, input logic [15:0] v);
    logic [7:0] b[4];
    b[0] = 8'(int'(ADDR) * 2);
    b[1] = gpio ? 8'h12 : 8'h00;
    b[2] = gpio ? v[7:0] : 8'h00;
    b[3] = gpio ? v[15:8] : 8'h00;
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, b[i]});
  endfunction

  // Transmitter model and scoreboard monitor: drives tx_ready/tx_done, pops and compares bytes.
  initial begin
    logic [8:0] e;
    tx_ready = 1'b1;
    tx_done  = 1'b0;
    tx_nack  = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      tx_nack = 1'b0;
      if (rst) begin
        done_timer = 0;
        byte_cnt   = 0;
        tx_ready   = 1'b1;
      end else begin
        if (done_timer > 0) begin
          done_timer--;
          if (done_timer == 0) begin
            tx_done = 1'b1;
            tx_nack = (nack_left > 0);
            if (nack_left > 0) nack_left--;
          end
        end
        tx_ready = !(tx_valid && byte_cnt == 2 && stall_left > 0);
        if (tx_valid && !tx_ready) begin
          stall_left--;
          stall_hits++;
          n_cmp++;
          if (exp_q.size() == 0 || {tx_last, tx_data} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL stall_hold: got %0h expected %0h", {tx_last, tx_data},
                     exp_q.size() == 0 ? 9'h0 : exp_q[0]);
          end
        end
        if (tx_valid && tx_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none", {tx_last, tx_data});
          end else begin
            e = exp_q.pop_front();
            if ({tx_last, tx_data} !== e) begin
              n_fail++;
              $display("FAIL tx_byte: got %0h expected %0h", {tx_last, tx_data}, e);
            end
          end
          if (tx_last) begin
            byte_cnt   = 0;
            done_timer = 2;
          end else begin
            byte_cnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (err === 1'b1) err_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic reset_check(input string name);
    rst = 1'b1;
    #1;
    chk({name, "_tx_valid"}, tx_valid, 0);
    chk({name, "_tx_data"}, tx_data, 0);
    chk({name, "_tx_last"}, tx_last, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_fault"}, fault, 0);
    chk({name, "_init_done"}, init_done, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_port_ready"}, port_ready, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic release_check(input string name);
    int c = 0;
    rst = 1'b0;
    while (tx_valid !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk(name, c, SC);
    chk({name, "_busy"}, busy, 1);
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk(name, (exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic offer(input logic [15:0] v, input string name);
    port_valid = 1'b1;
    port_data  = v;
    chk(name, port_ready, 1);
    @(negedge clk);
    port_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int          e0;
    int          c;
    @(negedge clk);
    reset_check("rst0");
    push_frame(0, 16'h0);
    release_check("first_valid");
    wait_drain("init_drain");
    chk("init_done", init_done, 1);
    chk("no_fault", fault, 0);

    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 16'hA55A : 16'($urandom);
      push_frame(1, v);
      offer(v, "gpio_ready");
      wait_drain("gpio_drain");
    end
    repeat (2) @(negedge clk);
    chk("no_err", err_cnt, 0);

    push_frame(1, 16'h1234);
    offer(16'h1234, "coal_ready0");
    c = 0;
    while (!busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    offer(16'h0001, "coal_ready1");
    offer(16'h0002, "coal_ready2");
    offer(16'h0003, "coal_ready3");
    push_frame(1, 16'h0003);
    wait_drain("coal_drain");
    repeat (20) @(negedge clk);
    chk("coal_idle", busy, 0);

    e0 = err_cnt;
    v  = 16'($urandom);
    nack_left = 3;
    for (int i = 0; i < 3; i++) push_frame(1, v);
    offer(v, "retry_ready");
    wait_drain("retry_drain");
    repeat (2) @(negedge clk);
    chk("retry_err_once", err_cnt - e0, 1);
    v = 16'($urandom);
    push_frame(1, v);
    offer(v, "after_retry_ready");
    wait_drain("after_retry_drain");
    repeat (2) @(negedge clk);
    chk("after_retry_no_err", err_cnt - e0, 1);

    e0 = stall_hits;
    stall_left = 5;
    v = 16'($urandom);
    push_frame(1, v);
    offer(v, "stall_ready");
    wait_drain("stall_drain");
    chk("stall_cycles", stall_hits - e0, 5);

    v = 16'($urandom);
    push_frame(1, v);
    offer(v, "midrst_ready");
    c = 0;
    while (byte_cnt != 2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("midrst_reached", byte_cnt, 2);
    reset_check("rst_mid");
    push_frame(0, 16'h0);
    release_check("restart_valid");
    wait_drain("reinit_drain");
    chk("reinit_done", init_done, 1);

    @(negedge clk);
    reset_check("rst_fault");
    nack_left = 3;
    for (int i = 0; i < 3; i++) push_frame(0, 16'h0);
    release_check("fault_first_valid");
    c = 0;
    while (!fault && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("fault_set", fault, 1);
    chk("fault_ready", port_ready, 0);
    chk("fault_busy", busy, 0);
    chk("fault_init_done", init_done, 0);
    chk("fault_frames_used", exp_q.size(), 0);
    port_valid = 1'b1;
    port_data  = 16'hBEEF;
    c = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_valid) c++;
    end
    port_valid = 1'b0;
    chk("fault_silent", c, 0);
    chk("fault_sticky", fault, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
